hazard_control_unit: RTL
========================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port id_rs1_addr / id_rs2_addr, inputs, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have port id_uses_rs1 / id_uses_rs2, inputs, 1 bit each: the ID instruction reads rs1 / rs2.
REQ-005 SHALL have port ex_rd_addr, input, 5 bits: rd of the instruction in EX, taken from the ID/EX buffer output.
REQ-006 SHALL have port ex_mem_read, input, 1 bit: the EX instruction is a load.
REQ-007 SHALL have port ex_branch_taken, input, 1 bit: the branch resolved in EX is taken (redirect).
REQ-008 SHALL have ports mem_req and mem_ready, inputs, 1 bit each: the MEM-stage access is pending / completes this cycle.
REQ-009 SHALL have port pipeline_stall, output, 1 bit: bubble request to the ID/EX buffer.
REQ-010 SHALL have ports pc_write, if_id_write and if_id_flush, outputs, 1 bit each: PC update enable, IF/ID capture enable, IF/ID clear-to-NOP.
REQ-011 SHALL have port global_freeze, output, 1 bit: all pipeline registers hold.
REQ-012 SHALL have port hazard_state, output, 2 bits: current FSM state.
REQ-013 SHALL have ports stall_count and flush_count, outputs, 16 bits each: performance counters.

Function
REQ-014 SHALL implement FSM states IDLE=0, LOAD_USE=1, FLUSH=2, MEM_WAIT=3, registered on the rising edge of clk.
REQ-015 SHALL define freeze_c = mem_req & ~mem_ready.
REQ-016 SHALL define lu_c = ex_mem_read & (ex_rd_addr!=0) & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)), with lu_c masked to 0 while the state is LOAD_USE or FLUSH.
REQ-017 SHALL resolve causes by fixed priority, evaluated combinationally each cycle: freeze_c > ex_branch_taken > lu_c.
REQ-018 SHALL, when freeze_c is true: global_freeze=1, pc_write=0, if_id_write=0, pipeline_stall=0, if_id_flush=0; next state MEM_WAIT.
REQ-019 SHALL, when taken is the winning cause: if_id_flush=1, pipeline_stall=1, pc_write=1, if_id_write=1; next state FLUSH.
REQ-020 SHALL, when lu_c is the winning cause: pipeline_stall=1, pc_write=0, if_id_write=0; next state LOAD_USE.
REQ-021 SHALL, when no cause is active: pc_write=1, if_id_write=1, and all other controls 0; next state IDLE.
REQ-022 SHALL cap every load-use stall at exactly one cycle, because lu_c is masked in LOAD_USE.
REQ-023 SHALL return from LOAD_USE or FLUSH to IDLE after one cycle unless a new cause is present.
REQ-024 SHALL leave MEM_WAIT in the cycle after mem_ready=1, going to the state selected by the other causes.
REQ-025 SHALL, when a branch is taken during freeze, suppress the flush until the freeze ends; the frozen EX keeps ex_branch_taken asserted, so the flush occurs in the first unfrozen cycle.
REQ-026 SHALL, when branch and load-use occur in the same cycle, flush only and not stall (the ID instruction is wrong-path).
REQ-027 SHALL never flag a hazard for x0, i.e. when ex_rd_addr==0.
REQ-028 SHALL increment stall_count on each clock edge where pipeline_stall (load-use) or global_freeze is 1, saturating at 0xFFFF.
REQ-029 SHALL increment flush_count once per cycle with if_id_flush=1, saturating at 0xFFFF.
REQ-030 SHALL produce control outputs with zero-cycle latency (Mealy, from state and current inputs); hazard_state and the counters SHALL be registered.

Reset
REQ-031 SHALL, while rst=1, force hazard_state=IDLE, stall_count=0 and flush_count=0, all asynchronously.
REQ-032 SHALL, while rst=1, drive pc_write=0, if_id_write=0, pipeline_stall=0, if_id_flush=0 and global_freeze=0.
REQ-033 SHALL, on rst asserted mid-stall or mid-freeze, abort immediately and restart in IDLE with no pending stall or flush after release.

Verification
REQ-034 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> exactly one cycle of pipeline_stall=1, pc_write=0; state LOAD_USE then IDLE; stall_count=1.
REQ-035 SHALL cover x0 and unused source: ex_rd=0 with rs1=0, or id_uses_rs2=0 with rs2 matching -> no stall.
REQ-036 SHALL cover branch taken combined with a load-use match -> if_id_flush=1, pipeline_stall=1, pc_write=1 for one cycle; flush_count=1, stall_count=0.
REQ-037 SHALL cover memory wait: mem_req=1, mem_ready=0 for 3 cycles while taken=1 -> global_freeze=1 for 3 cycles, no flush; flush in the 4th cycle; stall_count=3.
REQ-038 SHALL cover saturation: 70000 freeze cycles -> stall_count holds at 0xFFFF.
REQ-039 SHALL cover reset: rst pulsed during MEM_WAIT -> hazard_state=0, counters 0, all controls 0 during reset; pc_write=1 in the first cycle after release.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard control unit for a five-stage pipeline.
// Arbitrates memory freeze, taken-branch flush and load-use stall with a
// fixed priority, drives the pipeline enables combinationally and keeps
// saturating performance counters for stall and flush cycles.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no hazard handled in the previous cycle
// LOAD_USE | one-cycle load-use bubble was inserted last cycle
// FLUSH    | IF/ID was cleared for a taken branch last cycle
// MEM_WAIT | pipeline frozen waiting on the MEM-stage access
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pipeline_stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        global_freeze,
  output logic [1:0]  hazard_state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_USE = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic freeze_c;
  logic lu_raw;
  logic lu_c;
  logic lu_stall;

  // Raw hazard causes; load-use is masked right after a bubble or a flush
  // so a single load never stalls twice and wrong-path IDs never stall.
  always_comb begin
    freeze_c = mem_req & ~mem_ready;
    lu_raw   = ex_mem_read & (ex_rd_addr != 5'd0) &
               ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    lu_c     = lu_raw & (state_q != LOAD_USE) & (state_q != FLUSH);
  end

  // Priority arbitration: freeze over branch flush over load-use stall.
  // A branch seen during a freeze simply waits; EX is frozen so the taken
  // signal is still there in the first unfrozen cycle.
  always_comb begin
    state_d        = IDLE;
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    pipeline_stall = 1'b0;
    if_id_flush    = 1'b0;
    global_freeze  = 1'b0;
    lu_stall       = 1'b0;
    if (freeze_c) begin
      state_d       = MEM_WAIT;
      global_freeze = 1'b1;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
    end else if (ex_branch_taken) begin
      state_d        = FLUSH;
      if_id_flush    = 1'b1;
      pipeline_stall = 1'b1;
    end else if (lu_c) begin
      state_d        = LOAD_USE;
      pipeline_stall = 1'b1;
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      lu_stall       = 1'b1;
    end
    if (rst) begin
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      pipeline_stall = 1'b0;
      if_id_flush    = 1'b0;
      global_freeze  = 1'b0;
      lu_stall       = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign hazard_state = state_q;

  // Saturating counters: stalls count load-use bubbles and freeze cycles
  // (a branch flush also raises pipeline_stall but is counted as a flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if ((lu_stall | global_freeze) && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (if_id_flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule
